issue_entry_fifo: RTL and testbench

- Responder/consumer side of the decode-to-issue handshake: `issue_entry_i` / `issue_entry_valid_i` / `is_ctrl_flow_i` in, `issue_instr_ack_o` out.
- Buffers up to DEPTH decoded scoreboard entries in front of the issue stage, so issue-side stalls do not immediately back-pressure decode.
- Re-presents entries in program order to the issue stage over the same valid/ack protocol.
- Enforces issue-side serialisation rules: one control-flow entry in flight, CSR entries isolated.

---
 rtl/issue_entry_fifo.sv | 152 +++++++++++++++
 tb/tb_issue_entry_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_entry_fifo.sv
// Decode-to-issue entry FIFO with control-flow and CSR serialisation.
// Optional same-cycle bypass when empty: define ISSUE_FIFO_BYPASS_EN.

package ariane_pkg;
  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } scoreboard_entry_t;
endpackage

module issue_entry_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  ariane_pkg::scoreboard_entry_t    issue_entry_i,
  input  logic                             issue_entry_valid_i,
  input  logic                             is_ctrl_flow_i,
  output logic                             issue_instr_ack_o,
  output ariane_pkg::scoreboard_entry_t    issue_entry_o,
  output logic                             issue_entry_valid_o,
  output logic                             is_ctrl_flow_o,
  input  logic                             issue_instr_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ctrl_pending_q, ctrl_pending_d;
  logic             csr_pending_q, csr_pending_d;

  ariane_pkg::scoreboard_entry_t mem_q [DEPTH];
  ariane_pkg::scoreboard_entry_t mem_d [DEPTH];
  logic                          ctrl_mem_q [DEPTH];
  logic                          ctrl_mem_d [DEPTH];
  logic                          iev_q [DEPTH];
  logic                          iev_d [DEPTH];

  logic empty, full, ctrl_block, csr_block, bypass;
  logic pop, pop_stored, push_write;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign ctrl_block = is_ctrl_flow_i & ctrl_pending_q;
  assign csr_block  = csr_pending_q |
                      ((issue_entry_i.fu == ariane_pkg::CSR) & ~empty);

  // Gated by rst_ni so the handshake reads as idle while reset is held.
  assign issue_instr_ack_o = rst_ni & issue_entry_valid_i & ~full & ~flush_i &
                             ~ctrl_block & ~csr_block;

`ifdef ISSUE_FIFO_BYPASS_EN
  assign bypass = empty & issue_instr_ack_o;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    issue_entry_o       = '0;
    issue_entry_valid_o = 1'b0;
    is_ctrl_flow_o      = 1'b0;
    if (bypass) begin
      issue_entry_o       = issue_entry_i;
      issue_entry_valid_o = 1'b1;
      is_ctrl_flow_o      = is_ctrl_flow_i;
    end else if (!empty) begin
      issue_entry_o       = mem_q[rd_ptr_q];
      issue_entry_valid_o = iev_q[rd_ptr_q];
      is_ctrl_flow_o      = ctrl_mem_q[rd_ptr_q];
    end
  end

  assign pop        = issue_entry_valid_o & issue_instr_ack_i;
  assign pop_stored = pop & ~bypass;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign push_write = issue_instr_ack_o & ~(bypass & issue_instr_ack_i);

  always_comb begin
    mem_d      = mem_q;
    ctrl_mem_d = ctrl_mem_q;
    iev_d      = iev_q;
    if (push_write) begin
      mem_d[wr_ptr_q]      = issue_entry_i;
      ctrl_mem_d[wr_ptr_q] = is_ctrl_flow_i;
      iev_d[wr_ptr_q]      = issue_entry_valid_i;
    end
  end

  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q + CNT_W'(push_write) - CNT_W'(pop_stored);
    ctrl_pending_d = ctrl_pending_q;
    csr_pending_d  = csr_pending_q;
    if (pop_stored) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (ctrl_mem_q[rd_ptr_q]) ctrl_pending_d = 1'b0;
      if (mem_q[rd_ptr_q].fu == ariane_pkg::CSR) csr_pending_d = 1'b0;
    end
    if (push_write) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (is_ctrl_flow_i) ctrl_pending_d = 1'b1;
      if (issue_entry_i.fu == ariane_pkg::CSR) csr_pending_d = 1'b1;
    end
    if (flush_i) begin
      rd_ptr_d       = '0;
      wr_ptr_d       = '0;
      count_d        = '0;
      ctrl_pending_d = 1'b0;
      csr_pending_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      ctrl_pending_q <= 1'b0;
      csr_pending_q  <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      ctrl_pending_q <= ctrl_pending_d;
      csr_pending_q  <= csr_pending_d;
    end
  end

  // Payload storage carries no reset; outputs are masked while empty.
  always_ff @(posedge clk_i) begin
    mem_q      <= mem_d;
    ctrl_mem_q <= ctrl_mem_d;
    iev_q      <= iev_d;
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_issue_entry_fifo.sv
// Randomised plus directed bench for issue_entry_fifo against a queue-based model.
// Follows ISSUE_FIFO_BYPASS_EN to match whichever build of the design it is paired with.

module tb_issue_entry_fifo;
  import ariane_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);
`ifdef ISSUE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    scoreboard_entry_t e;
    logic              c;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              fl = 1'b0;
  scoreboard_entry_t ein = '0;
  logic              vin = 1'b0;
  logic              cin = 1'b0;
  logic              aci = 1'b0;
  logic              ack_o;
  scoreboard_entry_t eo;
  logic              vo;
  logic              co;
  logic [CNT_W-1:0]  cnt;

  int n_vec = 0;
  int n_err = 0;

  rec_t q[$];
  logic              x_ack, x_v, x_c;
  scoreboard_entry_t x_e;

  issue_entry_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .flush_i            (fl),
    .issue_entry_i      (ein),
    .issue_entry_valid_i(vin),
    .is_ctrl_flow_i     (cin),
    .issue_instr_ack_o  (ack_o),
    .issue_entry_o      (eo),
    .issue_entry_valid_o(vo),
    .is_ctrl_flow_o     (co),
    .issue_instr_ack_i  (aci),
    .count_o            (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic scoreboard_entry_t mk(input fu_t f);
    scoreboard_entry_t r;
    r.pc  = $urandom;
    r.fu  = f;
    r.op  = 8'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    return r;
  endfunction

  // Expected outputs from the model queue and the current inputs.
  task automatic model_eval();
    bit any_ctrl = 0;
    bit any_csr  = 0;
    foreach (q[i]) begin
      if (q[i].c) any_ctrl = 1;
      if (q[i].e.fu == CSR) any_csr = 1;
    end
    x_ack = vin && (q.size() < DEPTH) && !fl && !(cin && any_ctrl) && !any_csr &&
            !(ein.fu == CSR && q.size() != 0);
    if (q.size() > 0) begin
      x_v = 1'b1; x_e = q[0].e; x_c = q[0].c;
    end else if (BYP && x_ack) begin
      x_v = 1'b1; x_e = ein; x_c = cin;
    end else begin
      x_v = 1'b0; x_e = '0; x_c = 1'b0;
    end
  endtask

  task automatic model_clock();
    bit consumed = 0;
    if (fl) begin
      q.delete();
    end else begin
      if (x_v && aci) begin
        if (q.size() > 0) void'(q.pop_front());
        else consumed = 1;
      end
      if (x_ack && !consumed) q.push_back('{e: ein, c: cin});
    end
  endtask

  // Called at posedge+1; drives inputs, checks mid-cycle, advances one edge.
  task automatic step(input logic v, input scoreboard_entry_t e, input logic c,
                      input logic a, input logic f);
    vin = v; ein = e; cin = c; aci = a; fl = f;
    #2;
    model_eval();
    chk("ack_o",   128'(ack_o), 128'(x_ack));
    chk("valid_o", 128'(vo),    128'(x_v));
    chk("entry_o", 128'(eo),    128'(x_e));
    chk("ctrl_o",  128'(co),    128'(x_c));
    chk("count_o", 128'(cnt),   128'(q.size()));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  scoreboard_entry_t idle_e, cur, br1, br2, csr_e, alu_e;
  logic cur_v;

  initial begin
    idle_e = '0;
    vin = 1'b1; ein = mk(ALU);
    #3;
    chk("rst_ack",   128'(ack_o), 128'(0));
    chk("rst_valid", 128'(vo),    128'(0));
    chk("rst_count", 128'(cnt),   128'(0));
    chk("rst_entry", 128'(eo),    128'(0));
    chk("rst_ctrl",  128'(co),    128'(0));
    vin = 1'b0;
    #14 rst_ni = 1'b1;
    @(posedge clk); #1;

    // Fill then stall, then drain in order.
    for (int i = 0; i < 5; i++) step(1'b1, mk(ALU), 1'b0, 1'b0, 1'b0);
    chk("fill_cnt", 128'(cnt), 128'(4));
    for (int i = 0; i < 4; i++) step(1'b0, idle_e, 1'b0, 1'b1, 1'b0);
    chk("drain_cnt", 128'(cnt), 128'(0));

    // Control-flow limit.
    br1 = mk(CTRL_FLOW); br2 = mk(CTRL_FLOW);
    step(1'b1, br1, 1'b1, 1'b0, 1'b0);
    step(1'b1, br2, 1'b1, 1'b0, 1'b0);
    step(1'b1, br2, 1'b1, 1'b0, 1'b0);
    step(1'b1, br2, 1'b1, 1'b1, 1'b0);
    step(1'b1, br2, 1'b1, 1'b0, 1'b0);
    step(1'b0, idle_e, 1'b0, 1'b1, 1'b0);
    step(1'b0, idle_e, 1'b0, 1'b1, 1'b0);

    // CSR isolation.
    step(1'b1, mk(ALU), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(ALU), 1'b0, 1'b0, 1'b0);
    csr_e = mk(CSR); alu_e = mk(ALU);
    step(1'b1, csr_e, 1'b0, 1'b0, 1'b0);
    step(1'b1, csr_e, 1'b0, 1'b1, 1'b0);
    step(1'b1, csr_e, 1'b0, 1'b1, 1'b0);
    step(1'b1, csr_e, 1'b0, 1'b0, 1'b0);
    step(1'b1, alu_e, 1'b0, 1'b0, 1'b0);
    step(1'b1, alu_e, 1'b0, 1'b1, 1'b0);
    step(1'b1, alu_e, 1'b0, 1'b0, 1'b0);
    step(1'b0, idle_e, 1'b0, 1'b1, 1'b0);

    // Wrap-around with continuous push and pop.
    step(1'b1, mk(ALU), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, mk(ALU), 1'b0, 1'b1, 1'b0);
      chk("wrap_cnt", 128'(cnt), 128'(1));
    end
    step(1'b0, idle_e, 1'b0, 1'b1, 1'b0);

    // Flush with a pending producer, then a branch is taken at once.
    for (int i = 0; i < 3; i++) step(1'b1, mk(ALU), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(ALU), 1'b0, 1'b1, 1'b1);
    chk("flush_cnt", 128'(cnt), 128'(0));
    step(1'b1, mk(CTRL_FLOW), 1'b1, 1'b0, 1'b0);
    step(1'b0, idle_e, 1'b0, 1'b1, 1'b0);

    // Reset mid-stream with a producer still presenting.
    step(1'b1, mk(ALU), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(ALU), 1'b0, 1'b0, 1'b0);
    vin = 1'b1; ein = mk(ALU);
    rst_ni = 1'b0;
    #1;
    chk("mrst_ack",   128'(ack_o), 128'(0));
    chk("mrst_valid", 128'(vo),    128'(0));
    chk("mrst_count", 128'(cnt),   128'(0));
    chk("mrst_entry", 128'(eo),    128'(0));
    chk("mrst_ctrl",  128'(co),    128'(0));
    q.delete();
    #1 rst_ni = 1'b1;
    step(1'b1, mk(ALU), 1'b0, 1'b1, 1'b0);
    step(1'b0, idle_e, 1'b0, 1'b1, 1'b0);

    // Randomised traffic; the producer holds its entry until acknowledged.
    cur_v = 1'b0; cur = '0;
    for (int i = 0; i < 600; i++) begin
      int r;
      fu_t f;
      if (!cur_v && $urandom_range(0, 9) < 7) begin
        r = $urandom_range(0, 9);
        f = (r < 5) ? ALU : (r < 7) ? LOAD : (r < 9) ? CTRL_FLOW : CSR;
        cur = mk(f);
        cur_v = 1'b1;
      end
      step(cur_v, cur_v ? cur : idle_e, cur_v && cur.fu == CTRL_FLOW,
           1'($urandom_range(0, 1)), $urandom_range(0, 99) < 3);
      if (x_ack) cur_v = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
